uart_tx_frame_unit: RTL and testbench

//   UART transmitter upstream of the receive top module; drives its serial din line.

---
 rtl/uart_tx_frame_unit.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_frame_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_unit.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it LSB-first as
// start, 8 data bits, optional parity, 1 stop. Baud and parity encodings match the receiver.
// Optional feature: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry buffer ahead of the
// FSM, giving back-to-back frames with no idle gap. Without it, a single-byte handshake.
module uart_tx_frame_unit #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       ready,
    output logic       dout,
    output logic       active,
    output logic       done,
    output logic       parity_bit
);

    localparam int unsigned Div0 = CLK_FREQ / 2400;
    localparam int unsigned Div1 = CLK_FREQ / 4800;
    localparam int unsigned Div2 = CLK_FREQ / 9600;
    localparam int unsigned Div3 = CLK_FREQ / 19200;
    // Counter only has to reach Div0-1, the slowest rate.
    localparam int unsigned CntW = (Div0 > 1) ? $clog2(Div0) : 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      baud_q, baud_d;
    logic            par_en_q, par_en_d;
    logic            par_q, par_d;
    logic            done_q, done_d;

    logic [CntW-1:0] last_cnt;
    logic            tick;
    logic            load;

    // Next frame source: FIFO head when buffered, otherwise the live handshake inputs.
    logic            src_valid;
    logic [7:0]      src_data;
    logic [1:0]      src_baud;
    logic [1:0]      src_par;

`ifdef UART_TX_FIFO_EN
    localparam bit FifoEn = 1'b1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    // Each entry carries its own baud/parity so queued frames keep the config they were sent with.
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte then.
    assign ready      = !fifo_full || load;
    assign push       = send && ready;
    assign src_valid  = !fifo_empty;
    assign {src_par, src_baud, src_data} = mem_q[rd_ptr_q[PtrW-1:0]];

    // FIFO storage and pointers; reset drops all buffered bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PtrW-1:0]] <= {parity_type, baud_rate, data_in};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
`else
    localparam bit FifoEn = 1'b0;

    assign ready     = (state_q == StIdle);
    assign src_valid = send;
    assign src_data  = data_in;
    assign src_baud  = baud_rate;
    assign src_par   = parity_type;
`endif

    // Bit period end for the baud rate latched at frame start.
    always_comb begin
        last_cnt = CntW'(Div0 - 1);
        unique case (baud_q)
            2'b00: last_cnt = CntW'(Div0 - 1);
            2'b01: last_cnt = CntW'(Div1 - 1);
            2'b10: last_cnt = CntW'(Div2 - 1);
            2'b11: last_cnt = CntW'(Div3 - 1);
            default: last_cnt = CntW'(Div0 - 1);
        endcase
    end

    assign tick = (cnt_q == last_cnt);

    // Frame sequencing, baud counting and frame latching.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        baud_d   = baud_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        done_d   = 1'b0;
        load     = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (src_valid) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    // Buffered mode chains straight into the next start bit.
                    if (FifoEn && src_valid) begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d  = StStart;
            cnt_d    = '0;
            bit_d    = 3'd0;
            data_d   = src_data;
            baud_d   = src_baud;
            par_en_d = (src_par == 2'b01) || (src_par == 2'b10);
            unique case (src_par)
                2'b01:   par_d = ~^src_data;
                2'b10:   par_d = ^src_data;
                default: par_d = 1'b0;
            endcase
        end
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            data_q   <= 8'd0;
            baud_q   <= 2'b00;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            baud_q   <= baud_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            done_q   <= done_d;
        end
    end

    // Serial line value decoded from the current state.
    always_comb begin
        dout = 1'b1;
        unique case (state_q)
            StStart:  dout = 1'b0;
            StData:   dout = data_q[bit_q];
            StParity: dout = par_q;
            default:  dout = 1'b1;
        endcase
    end

    assign active     = (state_q != StIdle);
    assign done       = done_q;
    assign parity_bit = par_q;

endmodule

// File: tb/tb_uart_tx_frame_unit.sv
// Scoreboard bench for uart_tx_frame_unit at CLK_FREQ=96000 (DIV 40/20/10/5).
// Stimulus queues each expected frame; a monitor decodes dout bit by bit against the queue.
module tb_uart_tx_frame_unit;

    logic       clk;
    logic       reset;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] data_in;
    logic       send;
    logic       ready;
    logic       dout;
    logic       active;
    logic       done;
    logic       parity_bit;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         has_par;
        bit         par;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    uart_tx_frame_unit #(
        .CLK_FREQ  (96000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_rate  (baud_rate),
        .parity_type(parity_type),
        .data_in    (data_in),
        .send       (send),
        .ready      (ready),
        .dout       (dout),
        .active     (active),
        .done       (done),
        .parity_bit (parity_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pt,
                             input int div, input bit hp, input bit p, input bit ab);
        exp_t e;
        @(negedge clk);
        data_in     = d;
        baud_rate   = br;
        parity_type = pt;
        send        = 1'b1;
        e.data = d; e.div = div; e.has_par = hp; e.par = p; e.abort = ab;
        exp_q.push_back(e);
        if (!ab) exp_done++;
        @(posedge clk);
        #1;
        send = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(ready === 1'b1 && active === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    // Count every done pulse to catch spurious or missing ones.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Monitor: decode each frame on dout against the head of the expected queue.
    initial begin : monitor
        exp_t e;
        logic expb;
        bit   bit_ok;
        bit   aborted;
        int   nb;
        forever begin
            while (dout !== 1'b0 || reset !== 1'b0) @(negedge clk);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: start bit seen, expected no frame");
                while (active === 1'b1) @(negedge clk);
                @(negedge clk);
            end else begin
                e = exp_q.pop_front();
                nb = e.has_par ? 11 : 10;
                aborted = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    if (b == 0) expb = 1'b0;
                    else if (b <= 8) expb = e.data[b-1];
                    else if (b == 9 && e.has_par) expb = e.par;
                    else expb = 1'b1;
                    bit_ok = 1'b1;
                    for (int c = 0; c < e.div; c++) begin
                        if (reset === 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (dout !== expb) bit_ok = 1'b0;
                        @(negedge clk);
                    end
                    if (aborted) break;
                    check($sformatf("frame_%02h_bit%0d", e.data, b), bit_ok, 1);
                end
                check("abort", aborted, e.abort);
                if (aborted) begin
                    @(negedge clk);
                    check("abort_dout", dout, 1);
                    check("abort_ready", ready, 1);
                    check("abort_done", done, 0);
                end else begin
                    check($sformatf("frame_%02h_done", e.data), done, 1);
                    check($sformatf("frame_%02h_parity_bit", e.data), parity_bit,
                          e.has_par ? e.par : 1'b0);
`ifdef UART_TX_FIFO_EN
                    if (exp_q.size() > 0) check("zero_gap_start", dout, 0);
`else
                    check("done_ready", ready, 1);
                    check("done_dout_idle", dout, 1);
`endif
                end
            end
        end
    end

    // Stimulus.
    initial begin
        reset       = 1'b1;
        send        = 1'b0;
        data_in     = 8'h00;
        baud_rate   = 2'b00;
        parity_type = 2'b00;

        // T1: reset held 3 cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check("rst_dout", dout, 1);
            check("rst_ready", ready, 1);
            check("rst_active", active, 0);
            check("rst_done", done, 0);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_dout", dout, 1);
            check("post_rst_ready", ready, 1);
            check("post_rst_active", active, 0);
            check("post_rst_done", done, 0);
        end

        // T2: 0xA5, 2400 baud, odd parity -> parity bit 1, 440 cycles.
        send_byte(8'hA5, 2'b00, 2'b01, 40, 1'b1, 1'b1, 1'b0);
        wait_idle(600);

        // T3: 0x3C, 19200 baud, no parity -> 50 cycles.
        send_byte(8'h3C, 2'b11, 2'b00, 5, 1'b0, 1'b0, 1'b0);
        wait_idle(100);

        // T4: 0x07, 9600 baud, even parity; config changed mid-frame has no effect.
        send_byte(8'h07, 2'b10, 2'b10, 10, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        wait_idle(200);

        // T5: reset during data bit 3 of 0x00, then 0x55 with odd parity.
        send_byte(8'h00, 2'b11, 2'b00, 5, 1'b0, 1'b0, 1'b1);
        repeat (21) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_idle(100);
        send_byte(8'h55, 2'b11, 2'b01, 5, 1'b1, 1'b1, 1'b0);
        wait_idle(100);

`ifdef UART_TX_FIFO_EN
        // T6: while a frame is busy, 5 consecutive sends fill the FIFO; the 5th is refused.
        send_byte(8'h11, 2'b11, 2'b00, 5, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("fifo_ready_%0d", k), ready, (k < 4) ? 1 : 0);
            data_in     = 8'h20 + 8'(k);
            baud_rate   = 2'b11;
            parity_type = 2'b00;
            send        = 1'b1;
            if (k < 4) begin
                exp_q.push_back('{data: 8'h20 + 8'(k), div: 5, has_par: 1'b0, par: 1'b0,
                                  abort: 1'b0});
                exp_done++;
            end
        end
        @(posedge clk);
        #1;
        send = 1'b0;
        wait_idle(400);
`else
        // T7: send held high with new data every cycle; accepts land 51 cycles apart.
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        @(negedge clk);
        for (int i = 0; i <= 102; i++) begin
            data_in = 8'h10 + 8'(i);
            send    = 1'b1;
            if (i % 51 == 0) begin
                exp_q.push_back('{data: 8'h10 + 8'(i), div: 5, has_par: 1'b0, par: 1'b0,
                                  abort: 1'b0});
                exp_done++;
            end
            @(posedge clk);
            #1;
        end
        send = 1'b0;
        wait_idle(100);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
